// File: rtl/piece_sequencer_pkg.sv
// Piece codes and sequencer state shared by the sequencer, pattern generator and game FSM.
package tetris_pkg;

  typedef logic [4:0] piece_t;

  localparam piece_t PIECE_I    = 5'd0;
  localparam piece_t PIECE_O    = 5'd1;
  localparam piece_t PIECE_S    = 5'd2;
  localparam piece_t PIECE_Z    = 5'd3;
  localparam piece_t PIECE_L    = 5'd4;
  localparam piece_t PIECE_J    = 5'd5;
  localparam piece_t PIECE_T    = 5'd6;
  localparam piece_t PIECE_NONE = 5'd31;
  localparam int     NUM_PIECES = 7;

  typedef enum logic [1:0] {FILL0, FILL1, READY} seq_state_t;

endpackage

// File: rtl/piece_sequencer_if.sv
// Request/response bundle between the game FSM (master) and the piece sequencer (slave).
interface piece_sequencer_if;
  import tetris_pkg::*;

  logic   req;
  logic   hold_req;
  logic   valid;
  piece_t type_out;
  piece_t next_type;
  piece_t held_type;

  modport master (output req, hold_req, input valid, type_out, next_type, held_type);
  modport slave  (input req, hold_req, output valid, type_out, next_type, held_type);

endinterface

// File: rtl/piece_sequencer_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); advances every cycle out of reset.
// Latency: seed visible the cycle after a reset edge; no backpressure.
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // An all-zero state would lock up, so a zero seed is promoted to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= (seed == 16'd0) ? 16'h0001 : seed;
    end else begin
      q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    end
  end

endmodule

// File: rtl/piece_sequencer.sv
// 7-bag piece sequencer with one-piece preview; req advances in 1 cycle, back-to-back legal, no backpressure.
// Hold slot built only when PIECE_SEQ_HOLD_EN is defined; otherwise held_type is constant PIECE_NONE.
module piece_sequencer
  import tetris_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic               clk,
  input logic               rst,
  piece_sequencer_if.slave  sq
);

  seq_state_t  state;
  logic        valid_q;
  piece_t      type_q;
  piece_t      next_q;
  logic [6:0]  avail;
  logic [15:0] lfsr_q;
  logic [12:0] lfsr_unused;

  logic [2:0]  pick;
  piece_t      drawn;
  logic [6:0]  avail_cleared;
  logic [6:0]  avail_after;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .q    (lfsr_q)
  );

  assign lfsr_unused = lfsr_q[15:3];

  // First available slot scanning upward from start, wrapping modulo 7.
  function automatic logic [2:0] draw_pick(input logic [6:0] av, input logic [2:0] r);
    logic [2:0]  start;
    logic [2:0]  idx;
    int unsigned s;
    start     = (r == 3'd7) ? 3'd0 : r;
    draw_pick = start;
    for (int k = NUM_PIECES - 1; k >= 0; k--) begin
      s   = (int'(start) + k) % NUM_PIECES;
      idx = 3'(s);
      if (av[idx]) draw_pick = idx;
    end
  endfunction

  always_comb begin
    pick          = draw_pick(avail, lfsr_q[2:0]);
    drawn         = {2'b00, pick};
    avail_cleared = avail & ~(7'b1 << pick);
    avail_after   = (avail_cleared == 7'd0) ? 7'h7F : avail_cleared;
  end

`ifdef PIECE_SEQ_HOLD_EN
  piece_t held_q;
  logic   hold_used;
`else
  logic   hold_unused;
  assign hold_unused = sq.hold_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL0;
      valid_q <= 1'b0;
      type_q  <= PIECE_NONE;
      next_q  <= PIECE_NONE;
      avail   <= 7'h7F;
`ifdef PIECE_SEQ_HOLD_EN
      held_q    <= PIECE_NONE;
      hold_used <= 1'b0;
`endif
    end else begin
      case (state)
        FILL0: begin
          type_q <= drawn;
          avail  <= avail_after;
          state  <= FILL1;
        end
        FILL1: begin
          next_q  <= drawn;
          avail   <= avail_after;
          valid_q <= 1'b1;
          state   <= READY;
        end
        READY: begin
          if (sq.req) begin
            type_q <= next_q;
            next_q <= drawn;
            avail  <= avail_after;
`ifdef PIECE_SEQ_HOLD_EN
            hold_used <= 1'b0;
          end else if (sq.hold_req && !hold_used) begin
            hold_used <= 1'b1;
            if (held_q == PIECE_NONE) begin
              held_q <= type_q;
              type_q <= next_q;
              next_q <= drawn;
              avail  <= avail_after;
            end else begin
              // Plain swap: nothing is drawn, so the bag is untouched.
              held_q <= type_q;
              type_q <= held_q;
            end
`endif
          end
        end
        default: state <= FILL0;
      endcase
    end
  end

  assign sq.valid     = valid_q;
  assign sq.type_out  = type_q;
  assign sq.next_type = next_q;
`ifdef PIECE_SEQ_HOLD_EN
  assign sq.held_type = held_q;
`else
  assign sq.held_type = PIECE_NONE;
`endif

endmodule

// File: tb/tb_piece_sequencer.sv
// Directed bench for piece_sequencer: reset, bag permutation, preview, ignore, re-reset determinism, hold.
module tb_piece_sequencer;
  import tetris_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  piece_sequencer_if sq ();

  piece_sequencer dut (
    .clk (clk),
    .rst (rst),
    .sq  (sq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sq.req = 1'b0; sq.hold_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
  endtask

  // SEED 16'hACE1: first draw starts at 1 -> O, LFSR then 16'h59C3 starts at 3 -> Z.
  task automatic test_reset();
    rst = 1'b1; sq.req = 1'b0; sq.hold_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (sq.valid !== 1'b0 || sq.type_out !== PIECE_NONE || sq.next_type !== PIECE_NONE || sq.held_type !== PIECE_NONE)
        $display("FAIL reset_state cyc=%0d: valid=%b type=%0d next=%0d held=%0d, want 0/31/31/31", i, sq.valid, sq.type_out, sq.next_type, sq.held_type);
      else passed++;
    end
    rst = 1'b0;
    tick();
    checks++;
    if (sq.valid !== 1'b0) $display("FAIL valid_early: valid=%b, want 0", sq.valid);
    else passed++;
    tick();
    checks++;
    if (sq.valid !== 1'b1) $display("FAIL valid_rise: valid=%b, want 1", sq.valid);
    else passed++;
    checks++;
    if (sq.type_out !== PIECE_O || sq.next_type !== PIECE_Z)
      $display("FAIL first_pieces: type=%0d next=%0d, want 1/3", sq.type_out, sq.next_type);
    else passed++;
  endtask

  task automatic test_bag();
    piece_t     seq [70];
    piece_t     pn;
    logic [6:0] mask;
    seq[0] = sq.type_out;
    for (int r = 1; r < 70; r++) begin
      pn = sq.next_type;
      sq.req = 1'b1;
      tick();
      sq.req = 1'b0;
      checks++;
      if (sq.type_out !== pn || sq.valid !== 1'b1)
        $display("FAIL preview req=%0d: type=%0d valid=%b, want %0d/1", r, sq.type_out, sq.valid, pn);
      else passed++;
      seq[r] = sq.type_out;
      tick(); tick();
    end
    for (int g = 0; g < 10; g++) begin
      mask = 7'd0;
      for (int j = 0; j < 7; j++)
        if (seq[g*7+j] < 5'd7) mask[seq[g*7+j][2:0]] = 1'b1;
      checks++;
      if (mask !== 7'h7F) $display("FAIL bag_perm group=%0d: mask=%h, want 7f", g, mask);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    piece_t pn;
    sq.req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pn = sq.next_type;
      tick();
      checks++;
      if (sq.valid !== 1'b1 || sq.type_out !== pn)
        $display("FAIL burst i=%0d: valid=%b type=%0d, want 1/%0d", i, sq.valid, sq.type_out, pn);
      else passed++;
    end
    sq.req = 1'b0;
  endtask

  task automatic test_ignore_fill();
    rst = 1'b1; sq.req = 1'b0; sq.hold_req = 1'b0;
    tick();
    rst = 1'b0; sq.req = 1'b1; sq.hold_req = 1'b1;
    tick(); tick();
    sq.req = 1'b0; sq.hold_req = 1'b0;
    checks++;
    if (sq.valid !== 1'b1 || sq.type_out !== PIECE_O || sq.next_type !== PIECE_Z || sq.held_type !== PIECE_NONE)
      $display("FAIL fill_ignore: valid=%b type=%0d next=%0d held=%0d, want 1/1/3/31", sq.valid, sq.type_out, sq.next_type, sq.held_type);
    else passed++;
  endtask

  task automatic test_reset_midbag();
    piece_t s1 [5];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      s1[i] = sq.type_out;
      sq.req = 1'b1; tick(); sq.req = 1'b0; tick();
    end
    s1[3] = sq.type_out;
    s1[4] = sq.next_type;
    rst = 1'b1;
    tick();
    checks++;
    if (sq.valid !== 1'b0 || sq.type_out !== PIECE_NONE || sq.next_type !== PIECE_NONE || sq.held_type !== PIECE_NONE)
      $display("FAIL midbag_reset: valid=%b type=%0d next=%0d held=%0d, want 0/31/31/31", sq.valid, sq.type_out, sq.next_type, sq.held_type);
    else passed++;
    tick();
    rst = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sq.type_out !== s1[i]) $display("FAIL replay i=%0d: type=%0d, want %0d", i, sq.type_out, s1[i]);
      else passed++;
      sq.req = 1'b1; tick(); sq.req = 1'b0; tick();
    end
    checks++;
    if (sq.type_out !== s1[3] || sq.next_type !== s1[4])
      $display("FAIL replay_tail: type=%0d next=%0d, want %0d/%0d", sq.type_out, sq.next_type, s1[3], s1[4]);
    else passed++;
  endtask

  task automatic test_hold();
    piece_t a, b, c, d;
    do_reset();
    a = sq.type_out;
    b = sq.next_type;
`ifdef PIECE_SEQ_HOLD_EN
    sq.hold_req = 1'b1; tick(); sq.hold_req = 1'b0;
    c = sq.next_type;
    checks++;
    if (sq.held_type !== a || sq.type_out !== b || c > PIECE_T || c === a || c === b)
      $display("FAIL hold_first: held=%0d type=%0d next=%0d, want %0d/%0d/new", sq.held_type, sq.type_out, c, a, b);
    else passed++;
    sq.hold_req = 1'b1; tick(); sq.hold_req = 1'b0;
    checks++;
    if (sq.held_type !== a || sq.type_out !== b || sq.next_type !== c)
      $display("FAIL hold_repeat: held=%0d type=%0d next=%0d, want %0d/%0d/%0d", sq.held_type, sq.type_out, sq.next_type, a, b, c);
    else passed++;
    sq.req = 1'b1; tick(); sq.req = 1'b0;
    d = sq.next_type;
    checks++;
    if (sq.type_out !== c) $display("FAIL hold_req_adv: type=%0d, want %0d", sq.type_out, c);
    else passed++;
    sq.hold_req = 1'b1; tick(); sq.hold_req = 1'b0;
    checks++;
    if (sq.type_out !== a || sq.held_type !== c || sq.next_type !== d)
      $display("FAIL hold_swap: type=%0d held=%0d next=%0d, want %0d/%0d/%0d", sq.type_out, sq.held_type, sq.next_type, a, c, d);
    else passed++;
`else
    c = PIECE_NONE;
    d = PIECE_NONE;
    sq.hold_req = 1'b1; tick(); sq.hold_req = 1'b0;
    checks++;
    if (sq.held_type !== PIECE_NONE || sq.type_out !== a || sq.next_type !== b)
      $display("FAIL hold_disabled: held=%0d type=%0d next=%0d, want 31/%0d/%0d (c=%0d d=%0d)", sq.held_type, sq.type_out, sq.next_type, a, b, c, d);
    else passed++;
`endif
  endtask

  task automatic test_simultaneous();
    piece_t h, pn;
    h  = sq.held_type;
    pn = sq.next_type;
    sq.req = 1'b1; sq.hold_req = 1'b1;
    tick();
    sq.req = 1'b0; sq.hold_req = 1'b0;
    checks++;
    if (sq.type_out !== pn || sq.held_type !== h)
      $display("FAIL req_and_hold: type=%0d held=%0d, want %0d/%0d", sq.type_out, sq.held_type, pn, h);
    else passed++;
  endtask

  initial begin
    sq.req = 1'b0;
    sq.hold_req = 1'b0;
    test_reset();
    test_bag();
    test_back_to_back();
    test_ignore_fill();
    test_reset_midbag();
    test_hold();
    test_simultaneous();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/piece_sequencer.md
Name: piece_sequencer

Overview:
- Produces the piece-type code stream that drives the pattern generator (`current_block_type`, codes 0..6 = I,O,S,Z,L,J,T).
- Uses a 7-bag randomizer: every aligned group of 7 drawn pieces is a permutation of 0..6.
- Keeps a one-piece preview and answers single-cycle request pulses from the game control FSM.
- Sits between the game FSM (requester) and the pattern generator (consumer of `type_out`).

Parameters:
- SEED, 16'hACE1, non-zero initial LFSR state loaded on reset. A SEED of 0 is illegal and is replaced by 16'h0001.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- req  in  1  pulse: consume current piece, advance stream
- hold_req  in  1  pulse: swap current piece with hold slot (used only with the optional feature)
- valid  out  1  type_out/next_type are meaningful
- type_out  out  5  current piece type, 0..6, or PIECE_NONE (5'd31)
- next_type  out  5  preview piece type, 0..6, or PIECE_NONE
- held_type  out  5  hold-slot piece, or PIECE_NONE

Behaviour:
- Reset values on a clk edge with rst=1: valid=0, type_out=next_type=held_type=PIECE_NONE, bag mask avail=7'h7F, LFSR=SEED, hold_used=0, state=FILL0.
  - PIECE_NONE makes the pattern generator emit an empty pattern.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; shifts left, feedback into bit 0.
  - Advances every cycle rst=0, free-running, so player timing adds entropy.
- Draw function, combinational, single cycle:
  - start = (lfsr[2:0]==7) ? 0 : lfsr[2:0].
  - pick = first index i with avail[i]=1, scanning start, start+1, … modulo 7.
  - The draw clears avail[pick].
  - If avail becomes 0 after the clear, avail loads 7'h7F in the same cycle instead.
  - avail is never all-zero when sampled.
- FSM:
  - FILL0: draw into type_out → FILL1.
  - FILL1: draw into next_type; valid←1 → READY. valid is first high on the 2nd cycle after rst deasserts.
  - READY, req=1: type_out←next_type; next_type←draw; hold_used←0. Latency 1 cycle; valid stays 1. Back-to-back req every cycle is legal.
- req or hold_req in FILL0/FILL1: ignored, not queued.
- req and hold_req in the same cycle: req wins; hold_req is dropped.
- rst mid-operation: returns to the reset values regardless of state; the bag and the hold slot are discarded.
- Determinism: the same SEED and the same req cycle timing give an identical sequence.

Optional Feature:
- Macro: PIECE_SEQ_HOLD_EN.
- Defined — in READY, with hold_req=1, req=0 and hold_used=0:
  - If held_type==PIECE_NONE: held_type←type_out; type_out←next_type; next_type←draw.
  - Otherwise: swap type_out and held_type; the bag is unchanged.
  - Either case sets hold_used=1, cleared by the next req.
  - hold_req while hold_used=1 is ignored.
- Undefined:
  - hold_req is ignored and held_type is constant PIECE_NONE.
  - No hold_used register exists; the port list is unchanged.

Decomposition:
- Package tetris_pkg:
  - Piece-code constants PIECE_I..PIECE_T (0..6), PIECE_NONE=5'd31, NUM_PIECES=7.
  - typedef piece_t (logic [4:0]).
  - seq_state_t enum {FILL0, FILL1, READY}.
  - These are shared with the pattern generator and the game FSM.
- Sub-module lfsr16, with ports clk, rst, seed, q[15:0]; it is natural and reusable for a future garbage-row generator.
- Draw/scan logic stays inline as a function.

Test Plan:
- Reset: rst high for 3 cycles then low → valid=0, type_out=next_type=held_type=31 during reset; valid=1 exactly 2 cycles after deassert; both outputs in 0..6 and different from each other.
- Bag property: after valid, issue 69 req pulses (1 per 3 cycles) → type_out values 1–7, 8–14, …, 64–70 are each a permutation of 0..6.
- Preview: req in READY → next cycle type_out equals the prior next_type; req held high 10 consecutive cycles → 10 advances, valid never drops.
- Ignore and reset: req during FILL0/FILL1 → no extra advance. rst asserted mid-bag after 3 reqs → state matches a fresh reset, and the sequence repeats the post-reset sequence when req timing is identical.
- Hold (macro defined):
  - First hold_req with type_out=A, next=B → held=A, type_out=B.
  - Second hold_req before a req → ignored.
  - After req, hold_req → swap of type_out and A.
  - Macro undefined → held_type stays 31 and type_out is unchanged.
- Simultaneous req and hold_req → only the req advance occurs; held_type is unchanged.
